// File: rtl/vga_timing.sv
// vga_timing: raster timing generator feeding the bitmap pixel mapper.
//   clk         pixel-domain clock
//   rst_n       asynchronous active-low reset
//   en          pixel-advance enable (tie 1 when clk is the pixel clock)
//   posx        current column inside the active area, else 0
//   posy        current row inside the active area, else 0
//   active      undelayed visible-area flag
//   line_start  one-clk pulse at hcnt==0 on an enabled clk
//   frame_start one-clk pulse at hcnt==0, vcnt==0 on an enabled clk
//   hsync       horizontal sync, PIPE_DLY enabled clks late
//   vsync       vertical sync, PIPE_DLY enabled clks late
//   de_out      active, PIPE_DLY enabled clks late
//   frame_cnt   free-running frame counter
module vga_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       de_out,
    output logic [7:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]          hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [7:0]          frame_q, frame_d;
    // Delay lines carry "asserted" flags; polarity is applied at the pins so
    // that a cleared stage always means the deasserted level.
    logic [PIPE_DLY-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic                h_wrap, v_wrap, hs_raw, vs_raw;

    always_comb begin
        h_wrap  = hcnt_q == H_LAST;
        v_wrap  = vcnt_q == V_LAST;
        hcnt_d  = !en ? hcnt_q : h_wrap ? '0 : hcnt_q + 10'd1;
        vcnt_d  = !(en && h_wrap) ? vcnt_q : v_wrap ? '0 : vcnt_q + 10'd1;
        frame_d = (en && h_wrap && v_wrap) ? frame_q + 8'd1 : frame_q;
        hs_raw  = hcnt_q >= HS_BEG && hcnt_q < HS_END;
        vs_raw  = vcnt_q >= VS_BEG && vcnt_q < VS_END;
        hs_d    = en ? PIPE_DLY'({hs_q, hs_raw}) : hs_q;
        vs_d    = en ? PIPE_DLY'({vs_q, vs_raw}) : vs_q;
        de_d    = en ? PIPE_DLY'({de_q, active}) : de_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
            de_q    <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            frame_q <= frame_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
        end
    end

    // Pulses are gated by rst_n so they stay low while reset holds the
    // counters at the origin.
    always_comb begin
        active      = hcnt_q < H_ACT && vcnt_q < V_ACT;
        posx        = hcnt_q < H_ACT ? hcnt_q : '0;
        posy        = vcnt_q < V_ACT ? vcnt_q[8:0] : '0;
        line_start  = rst_n && en && hcnt_q == '0;
        frame_start = line_start && vcnt_q == '0;
        hsync       = hs_q[PIPE_DLY-1] ? HS_POL : ~HS_POL;
        vsync       = vs_q[PIPE_DLY-1] ? VS_POL : ~VS_POL;
        de_out      = de_q[PIPE_DLY-1];
        frame_cnt   = frame_q;
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing against a tick-count model.
module tb_vga_timing;
    localparam int   HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int   VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int   PD = 2;
    localparam logic HP = 1'b1, VP = 1'b0;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1;
    logic [9:0] posx;
    logic [8:0] posy;
    logic       active, line_start, frame_start, hsync, vsync, de_out;
    logic [7:0] frame_cnt;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .PIPE_DLY(PD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .posx(posx), .posy(posy), .active(active),
        .line_start(line_start), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .de_out(de_out),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    logic [32:0] sb[$];
    int          errors = 0, checks = 0;
    bit          done = 0;
    longint      n = 0;

    // Everything follows from t = number of enabled clks since reset.
    function automatic logic [32:0] model(longint t, logic e, logic r);
        longint     h, v, d, hd, vd;
        logic       act, ls, fs, hsa, vsa, de;
        logic [9:0] px;
        logic [8:0] py;
        logic [7:0] fc;
        h   = t % HT;
        v   = (t / HT) % VT;
        fc  = 8'((t / (HT * VT)) % 256);
        act = h < HA && v < VA;
        px  = h < HA ? 10'(h) : 10'd0;
        py  = v < VA ? 9'(v) : 9'd0;
        ls  = e && r && h == 0;
        fs  = ls && v == 0;
        hsa = 1'b0;
        vsa = 1'b0;
        de  = 1'b0;
        d   = t - PD;
        if (d >= 0) begin
            hd  = d % HT;
            vd  = (d / HT) % VT;
            hsa = hd >= HA + HF && hd < HA + HF + HS;
            vsa = vd >= VA + VF && vd < VA + VF + VS;
            de  = hd < HA && vd < VA;
        end
        return {px, py, act, ls, fs, hsa ? HP : ~HP, vsa ? VP : ~VP, de, fc};
    endfunction

    task automatic step(input logic e, input logic r);
        @(negedge clk);
        rst_n = r;
        en    = e;
        if (!r) n = 0;
        sb.push_back(model(n, e, r));
        if (e && r) n++;
    endtask

    // Monitor: samples mid low-phase, so a reset asserted at the falling
    // edge is observed before any rising clock edge.
    initial begin
        logic [32:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {posx, posy, active, line_start, frame_start,
                         hsync, vsync, de_out, frame_cnt};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs @%0t: got %h expected %h (posx,posy,act,ls,fs,hs,vs,de,fc)",
                             $time, act_v, exp_v);
                end
            end else if (!done) begin
                checks++;
                errors++;
                $display("FAIL scoreboard empty @%0t", $time);
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0);
        repeat (257 * HT * VT + 40) step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 1'b1);
        repeat (3000) step($urandom_range(0, 2) != 0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        repeat (400) step(1'($urandom_range(0, 1)), 1'b1);
        done = 1;
        repeat (2) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
